fp_add_subt_unit: RTL and testbench
===================================

Name: fp_add_subt_unit

Overview:
Multi-cycle IEEE-754-format floating-point adder/subtractor. It is the responder side of the beg_add_subt / ready_add_subt / ack_add_subt handshake driven by the CORDIC control FSM. It latches two operands on a start pulse and computes X+Y or X−Y through align, add and normalize stages. It then holds the result with ready asserted until acknowledged.

Parameters:
W, 32, total word width
EW, 8, exponent field width
SW, 23, stored significand (fraction) width; W = 1+EW+SW

Ports:
clk  in  1  system clock, rising edge
reset  in  1  reset, synchronous, active-high
beg_add_subt  in  1  start request; sampled only in IDLE
ack_add_subt  in  1  result accepted; sampled only in DONE
add_subt  in  1  0 = X+Y, 1 = X−Y; latched with operands
Data_X  in  W  operand X (sign | exponent | fraction)
Data_Y  in  W  operand Y
ready_add_subt  out  1  result valid; high only in DONE
busy  out  1  high in every state except IDLE
result  out  W  registered result
overflow_flag  out  1  registered, valid with ready
underflow_flag  out  1  registered, valid with ready

Behaviour:
- Reset: state=IDLE; ready_add_subt=0, busy=0, result=0, overflow_flag=0, underflow_flag=0; all internal registers cleared. A reset in any state aborts the operation, and outputs return to reset values on the next edge.
- States: IDLE, ALIGN, ADD, NORM, PACK, DONE.
- IDLE: if beg_add_subt=1, latch Data_X, Data_Y and add_subt, then go to ALIGN. Otherwise stay in IDLE.
- ALIGN (1 cycle):
  - Unpack operands; Y sign is inverted if add_subt=1.
  - An exponent field of 0 means the operand is zero: significand=0, sign kept, no hidden bit.
  - Otherwise the significand is {1, fraction} (SW+1 bits).
  - Compare magnitudes ({exp, frac}); the larger becomes A and the smaller B. On a tie, X is A.
  - Right-shift B's significand by expA−expB in one cycle (barrel shift). A shift of ≥SW+1 gives 0. Bits shifted out are discarded; there are no guard, round or sticky bits.
- ADD (1 cycle):
  - Effective operation is subtraction if signA≠signB, else addition.
  - Sum = A_sig ± B_sig, SW+2 bits wide. It is never negative because |A|≥|B|.
  - Result sign = signA; exponent = expA.
- NORM (1 cycle per step):
  - Sum = 0: result is +0 (sign cleared), no flags, go to PACK.
  - Carry bit (bit SW+1) set: shift right 1, drop the LSB, exponent+1, go to PACK.
  - Bit SW set: go to PACK.
  - Otherwise, if exponent>1: shift left 1, exponent−1, stay in NORM.
  - Otherwise (exponent ≤ 1 and still unnormalized): flush to zero keeping the sign, set underflow_flag, go to PACK.
- PACK (1 cycle):
  - If exponent ≥ 2^EW−1: result = {sign, all-ones exponent, zero fraction}, overflow_flag=1.
  - Otherwise result = {sign, exp[EW-1:0], sig[SW-1:0]}.
  - Go to DONE.
- DONE: ready_add_subt=1. result and flags stay stable until the ack_add_subt edge. On ack_add_subt=1, go to IDLE and drop ready on the next cycle. Flags are cleared on the next beg acceptance.
- Latency: 5 clock edges from the beg-sampling edge to ready high, plus 1 edge per left-normalization step.
- Handshake rules:
  - beg_add_subt while busy is ignored.
  - ack_add_subt outside DONE is ignored.
  - If beg and ack are both high in DONE, ack wins; beg is not captured and must be reissued in IDLE.
  - Input data may change freely after the latching edge.
- Input exponent all-ones (Inf/NaN) is not specially decoded. It is treated as a large normal number, which drives the overflow path.
- Rounding is truncation (toward zero); no denormal outputs.

Test Plan:
- 0x3F800000 + 0x3F800000 (add_subt=0) -> result 0x40000000 (2.0), flags 0, ready exactly 5 edges after beg.
- 0x3FC00000 − 0x3F800000 (1.5−1.0) -> result 0x3F000000 (0.5), 1 left shift, ready at 6 edges. Also 0x40400000 − 0x40400000 -> 0x00000000, ready at 5 edges.
- 0x3F800000 + 0x30800000 (1.0 + 2^-30) -> result 0x3F800000 (B aligned to 0). 0x00000000 − 0x3F800000 -> result 0xBF800000.
- 0x7F7FFFFF + 0x7F7FFFFF -> result 0x7F800000, overflow_flag=1. 0x00800001 − 0x00800000 -> result 0x00000000, underflow_flag=1.
- Handshake: hold ack=0 for 10 cycles in DONE -> ready and result stable. Pulse beg while busy -> no restart. ack=1 -> ready low next cycle, busy low.
- Assert reset during NORM of case 2 -> next edge state IDLE, ready=0, result=0. A new beg then completes normally with the correct result.

Source files
------------

// File: rtl/fp_add_subt_unit.sv
// rtl/fp_add_subt_unit.sv - multi-cycle truncating floating-point adder/subtractor
// Handshake responder: beg starts an operation, ready holds the result until ack.
module fp_add_subt_unit #(
  parameter int W  = 32,
  parameter int EW = 8,
  parameter int SW = 23
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         beg_add_subt,
  input  logic         ack_add_subt,
  input  logic         add_subt,
  input  logic [W-1:0] Data_X,
  input  logic [W-1:0] Data_Y,
  output logic         ready_add_subt,
  output logic         busy,
  output logic [W-1:0] result,
  output logic         overflow_flag,
  output logic         underflow_flag
);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, PACK, DONE} state_t;

  localparam logic [EW-1:0] SHIFT_LIMIT = EW'(SW + 1);
  localparam logic [EW:0]   EXP_MAX     = {1'b0, {EW{1'b1}}};
  localparam logic [EW:0]   EXP_ONE     = (EW+1)'(1);

  state_t state, state_nxt;

  logic [W-1:0]  x_q, y_q;
  logic          op_q;
  logic          a_sign, b_sign;
  logic [EW-1:0] a_exp;
  logic [SW:0]   a_sig, b_sig;
  logic          r_sign;
  logic [EW:0]   r_exp;     // one extra bit so the carry out of the top exponent is visible
  logic [SW+1:0] r_sig;

  // Alignment datapath, evaluated from the latched operands
  logic          y_sign_eff, swap;
  logic [SW:0]   x_sig, y_sig, al_a_sig, al_b_sig, al_b_shifted;
  logic [EW-1:0] al_a_exp, al_b_exp, exp_diff;
  logic [SW+1:0] sum;

  always_comb begin
    y_sign_eff   = y_q[W-1] ^ op_q;
    x_sig        = (x_q[W-2:SW] == '0) ? '0 : {1'b1, x_q[SW-1:0]};
    y_sig        = (y_q[W-2:SW] == '0) ? '0 : {1'b1, y_q[SW-1:0]};
    swap         = y_q[W-2:0] > x_q[W-2:0];
    al_a_exp     = swap ? y_q[W-2:SW] : x_q[W-2:SW];
    al_b_exp     = swap ? x_q[W-2:SW] : y_q[W-2:SW];
    al_a_sig     = swap ? y_sig : x_sig;
    al_b_sig     = swap ? x_sig : y_sig;
    exp_diff     = al_a_exp - al_b_exp;
    al_b_shifted = (exp_diff >= SHIFT_LIMIT) ? '0 : (al_b_sig >> exp_diff);
    sum          = (a_sign != b_sign) ? ({1'b0, a_sig} - {1'b0, b_sig})
                                      : ({1'b0, a_sig} + {1'b0, b_sig});
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    ready_add_subt = 1'b0;
    busy           = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (beg_add_subt) state_nxt = ALIGN;
      end
      ALIGN: state_nxt = ADD;
      ADD:   state_nxt = NORM;
      NORM: begin
        if (r_sig != '0 && !r_sig[SW+1] && !r_sig[SW] && r_exp > EXP_ONE) state_nxt = NORM;
        else state_nxt = PACK;
      end
      PACK: state_nxt = DONE;
      DONE: begin
        ready_add_subt = 1'b1;
        if (ack_add_subt) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q            <= '0;
      y_q            <= '0;
      op_q           <= 1'b0;
      a_sign         <= 1'b0;
      b_sign         <= 1'b0;
      a_exp          <= '0;
      a_sig          <= '0;
      b_sig          <= '0;
      r_sign         <= 1'b0;
      r_exp          <= '0;
      r_sig          <= '0;
      result         <= '0;
      overflow_flag  <= 1'b0;
      underflow_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (beg_add_subt) begin
            x_q            <= Data_X;
            y_q            <= Data_Y;
            op_q           <= add_subt;
            overflow_flag  <= 1'b0;
            underflow_flag <= 1'b0;
          end
        end
        ALIGN: begin
          a_sign <= swap ? y_sign_eff : x_q[W-1];
          b_sign <= swap ? x_q[W-1] : y_sign_eff;
          a_exp  <= al_a_exp;
          a_sig  <= al_a_sig;
          b_sig  <= al_b_shifted;
        end
        ADD: begin
          r_sign <= a_sign;
          r_exp  <= {1'b0, a_exp};
          r_sig  <= sum;
        end
        NORM: begin
          if (r_sig == '0) begin
            r_sign <= 1'b0;
            r_exp  <= '0;
          end else if (r_sig[SW+1]) begin
            r_sig <= r_sig >> 1;
            r_exp <= r_exp + EXP_ONE;
          end else if (!r_sig[SW]) begin
            if (r_exp > EXP_ONE) begin
              r_sig <= r_sig << 1;
              r_exp <= r_exp - EXP_ONE;
            end else begin
              // Would need a denormal: flush to signed zero instead
              r_sig          <= '0;
              r_exp          <= '0;
              underflow_flag <= 1'b1;
            end
          end
        end
        PACK: begin
          if (r_exp >= EXP_MAX) begin
            result        <= {r_sign, {EW{1'b1}}, {SW{1'b0}}};
            overflow_flag <= 1'b1;
          end else begin
            result <= {r_sign, r_exp[EW-1:0], r_sig[SW-1:0]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_subt_unit.sv
// tb/tb_fp_add_subt_unit.sv - scoreboard bench for fp_add_subt_unit
// Directed cases plus random operands checked against an integer reference model.
module tb_fp_add_subt_unit;

  logic        clk = 1'b0;
  logic        reset, beg_add_subt, ack_add_subt, add_subt;
  logic [31:0] Data_X, Data_Y;
  logic        ready_add_subt, busy, overflow_flag, underflow_flag;
  logic [31:0] result;

  fp_add_subt_unit #(.W(32), .EW(8), .SW(23)) dut (
    .clk(clk), .reset(reset),
    .beg_add_subt(beg_add_subt), .ack_add_subt(ack_add_subt), .add_subt(add_subt),
    .Data_X(Data_X), .Data_Y(Data_Y),
    .ready_add_subt(ready_add_subt), .busy(busy), .result(result),
    .overflow_flag(overflow_flag), .underflow_flag(underflow_flag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    int          lat;
    int          issue;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: integer significands, exact alignment loss, truncating normalisation
  function automatic void model(input logic [31:0] x, input logic [31:0] y, input logic op,
                                output logic [31:0] res, output logic ovf, output logic unf,
                                output int shifts);
    int ex, ey, mx, my, ea, eb, ma, mb, d, s, e;
    logic sx, sy, sa, sb, sg;
    sx = x[31];
    sy = y[31] ^ op;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    mx = (ex == 0) ? 0 : int'(x[22:0]) + (1 << 23);
    my = (ey == 0) ? 0 : int'(y[22:0]) + (1 << 23);
    if (y[30:0] > x[30:0]) begin
      ea = ey; eb = ex; ma = my; mb = mx; sa = sy; sb = sx;
    end else begin
      ea = ex; eb = ey; ma = mx; mb = my; sa = sx; sb = sy;
    end
    d  = ea - eb;
    mb = (d >= 24) ? 0 : (mb >> d);
    s  = (sa != sb) ? ma - mb : ma + mb;
    e  = ea;
    sg = sa;
    ovf = 1'b0;
    unf = 1'b0;
    shifts = 0;
    if (s == 0) begin
      sg = 1'b0;
      e  = 0;
    end else if (s >= (1 << 24)) begin
      s = s >> 1;
      e = e + 1;
    end else begin
      while (s != 0 && s < (1 << 23)) begin
        if (e > 1) begin
          s = s << 1;
          e = e - 1;
          shifts++;
        end else begin
          s = 0;
          e = 0;
          unf = 1'b1;
        end
      end
    end
    if (e >= 255) begin
      res = {sg, 8'hFF, 23'h0};
      ovf = 1'b1;
    end else begin
      res = {sg, e[7:0], s[22:0]};
    end
  endfunction

  // Monitor: checks each DONE entry against the head of the scoreboard
  exp_t mon_e;
  logic rdy_prev = 1'b0;
  always @(negedge clk) begin
    if (!reset && ready_add_subt && !rdy_prev) begin
      if (sbq.size() == 0) begin
        chk("unexpected_ready", 32'(ready_add_subt), 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("result", result, mon_e.res);
        chk("overflow_flag", 32'(overflow_flag), 32'(mon_e.ovf));
        chk("underflow_flag", 32'(underflow_flag), 32'(mon_e.unf));
        chk("latency", 32'(cyc - mon_e.issue), 32'(mon_e.lat));
      end
    end
    rdy_prev = ready_add_subt;
  end

  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic op,
                        input logic [31:0] er, input logic eo, input logic eu, input int el,
                        input int hold, input bit spur, input bit both);
    int n;
    @(negedge clk);
    Data_X = x; Data_Y = y; add_subt = op; beg_add_subt = 1'b1;
    sbq.push_back('{er, eo, eu, el, cyc});
    @(negedge clk);
    beg_add_subt = 1'b0;
    Data_X = $urandom; Data_Y = $urandom; add_subt = 1'($urandom);
    if (spur) begin
      beg_add_subt = 1'b1;
      @(negedge clk);
      beg_add_subt = 1'b0;
    end
    n = 0;
    while (!ready_add_subt && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!ready_add_subt) begin
      chk("ready_timeout", 32'(ready_add_subt), 32'd1);
      sbq.delete();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      return;
    end
    repeat (hold) begin
      @(negedge clk);
      chk("hold_ready", 32'(ready_add_subt), 32'd1);
      chk("hold_result", result, er);
    end
    ack_add_subt = 1'b1;
    if (both) beg_add_subt = 1'b1;
    @(negedge clk);
    ack_add_subt = 1'b0;
    beg_add_subt = 1'b0;
    chk("ack_ready_low", 32'(ready_add_subt), 32'd0);
    chk("ack_busy_low", 32'(busy), 32'd0);
  endtask

  task automatic run_rand(input logic [31:0] x, input logic [31:0] y, input logic op, input int hold);
    logic [31:0] r;
    logic o, u;
    int sh;
    model(x, y, op, r, o, u, sh);
    run_op(x, y, op, r, o, u, 5 + sh, hold, 1'b0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] x, y;
    int ey;
    reset = 1'b1; beg_add_subt = 1'b0; ack_add_subt = 1'b0; add_subt = 1'b0;
    Data_X = '0; Data_Y = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready_add_subt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {30'd0, overflow_flag, underflow_flag}, 32'd0);
    reset = 1'b0;

    run_op(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0, 5, 0, 1'b0, 1'b0);
    run_op(32'h3FC00000, 32'h3F800000, 1'b1, 32'h3F000000, 1'b0, 1'b0, 6, 1, 1'b0, 1'b0);
    run_op(32'h40400000, 32'h40400000, 1'b1, 32'h00000000, 1'b0, 1'b0, 5, 0, 1'b0, 1'b0);
    run_op(32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 5, 0, 1'b0, 1'b0);
    run_op(32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 1'b0, 1'b0, 5, 0, 1'b0, 1'b0);
    run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0, 5, 0, 1'b0, 1'b0);
    run_op(32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 1'b0, 1'b1, 5, 0, 1'b0, 1'b0);
    run_op(32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 1'b0, 1'b0, 5, 10, 1'b1, 1'b0);
    run_op(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b0, 5, 2, 1'b0, 1'b1);

    // Reset while in NORM aborts the operation
    @(negedge clk);
    Data_X = 32'h3FC00000; Data_Y = 32'h3F800000; add_subt = 1'b1; beg_add_subt = 1'b1;
    @(negedge clk);
    beg_add_subt = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_ready", 32'(ready_add_subt), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_result", result, 32'd0);
    reset = 1'b0;
    run_op(32'h3FC00000, 32'h3F800000, 1'b1, 32'h3F000000, 1'b0, 1'b0, 6, 0, 1'b0, 1'b0);
    run_op(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 1'b0, 1'b0, 5, 0, 1'b0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      x = $urandom;
      case ($urandom_range(0, 3))
        0: y = $urandom;
        1: y = {1'($urandom), x[30:0]};
        default: begin
          ey = int'(x[30:23]) + int'($urandom_range(0, 4)) - 2;
          if (ey < 0) ey = 0;
          if (ey > 255) ey = 255;
          y = {1'($urandom), ey[7:0], 23'($urandom)};
        end
      endcase
      run_rand(x, y, 1'($urandom), int'($urandom_range(0, 2)));
    end

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
